// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration checks for the digit-serial adder.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // True when the digit width is legal for the given operand width.
  function automatic bit digit_cfg_ok(input int unsigned width, input int unsigned digit);
    return (width >= 1) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple slice made of full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    logic [DIGIT:0] c;
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[DIGIT];
    // Carry into the MSB cell, needed for signed overflow.
    cmsb = c[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-wide slice reused over NDIG cycles.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  sa_q;
  logic [WIDTH-1:0]  sb_q;
  logic [WIDTH-1:0]  res_q;
  logic              carry_q;

  logic [DIGIT-1:0]  dsum;
  logic              dcout;
  logic              dcmsb;
  logic [WIDTH-1:0]  res_next;
  logic              last;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a    (sa_q[DIGIT-1:0]),
    .b    (sb_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // New digit enters at the top; after NDIG shifts the register holds the full result.
  if (NDIG == 1) begin : g_single
    assign res_next = dsum;
  end else begin : g_multi
    assign res_next = {dsum, res_q[WIDTH-1:DIGIT]};
  end

  assign last      = (cnt_q == CntW'(NDIG - 1));
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  // FSM, operand shifters, carry flop and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sa_q    <= a;
            // Subtraction is A + ~B + 1; cin is ignored in that mode.
            sb_q    <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sa_q    <= sa_q >> DIGIT;
          sb_q    <= sb_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= dcout;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            sum       <= res_next;
            carry_out <= dcout;
            overflow  <= dcmsb ^ dcout;
            zero      <= (res_next == '0);
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: default, single-digit and 8/2 instances.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Instance 0: WIDTH=32, DIGIT=4
  logic        iv0 = 0, ir0, ov0, or0 = 1, cin0 = 0, sub0 = 0, co0, of0, z0;
  logic [31:0] a0 = 0, b0 = 0, s0;
  // Instance 1: WIDTH=32, DIGIT=32
  logic        iv1 = 0, ir1, ov1, or1 = 1, cin1 = 0, sub1 = 0, co1, of1, z1;
  logic [31:0] a1 = 0, b1 = 0, s1;
  // Instance 2: WIDTH=8, DIGIT=2
  logic        iv2 = 0, ir2, ov2, or2 = 1, cin2 = 0, sub2 = 0, co2, of2, z2;
  logic [7:0]  a2 = 0, b2 = 0, s2;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0),
    .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(s0), .carry_out(co0), .overflow(of0),
    .zero(z0)
  );
  digit_serial_adder #(.WIDTH(32), .DIGIT(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1), .overflow(of1),
    .zero(z1)
  );
  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
    .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(s2), .carry_out(co2), .overflow(of2),
    .zero(z2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on instance 0 and wait (bounded) for out_valid; returns cycles to valid.
  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic c,
                     input logic s, output int lat);
    a0 = a; b0 = b; cin0 = c; sub0 = s; iv0 = 1;
    step();
    iv0 = 0;
    // Operands are sampled only at acceptance; scramble them afterwards.
    a0 = ~a; b0 = ~b; cin0 = ~c; sub0 = ~s;
    lat = 0;
    while (!ov0 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  int lat;

  initial begin
    #2;
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_sum", s0, 32'd0);
    chk("rst_flags", {29'd0, co0, of0, z0}, 32'd0);
    #10 rst_n = 1'b1;
    step();

    op0(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
    chk("wrap_latency", 32'(lat), 32'd8);
    chk("wrap_sum", s0, 32'd0);
    chk("wrap_flags", {29'd0, co0, of0, z0}, 32'b101);
    step();

    op0(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
    chk("ovf_sum", s0, 32'h8000_0000);
    chk("ovf_flags", {29'd0, co0, of0, z0}, 32'b010);
    step();

    op0(32'd3, 32'd4, 1'b1, 1'b0, lat);
    chk("cin_sum", s0, 32'd8);
    step();

    op0(32'd5, 32'd7, 1'b0, 1'b1, lat);
    chk("sub57_sum", s0, 32'hFFFF_FFFE);
    chk("sub57_flags", {29'd0, co0, of0, z0}, 32'b000);
    step();

    op0(32'd7, 32'd5, 1'b0, 1'b1, lat);
    chk("sub75_sum", s0, 32'd2);
    chk("sub75_flags", {29'd0, co0, of0, z0}, 32'b100);
    step();

    op0(32'd7, 32'd5, 1'b1, 1'b1, lat);
    chk("subcin_sum", s0, 32'd2);
    chk("subcin_co", 32'(co0), 32'd1);
    step();

    // Backpressure: result held while out_ready is low.
    or0 = 0;
    op0(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    chk("bp_sum0", s0, 32'h2345_6789);
    for (int i = 0; i < 5; i++) begin
      iv0 = ~iv0; a0 = a0 + 32'h0101; b0 = b0 ^ 32'hFF00;
      step();
    end
    chk("bp_sum_held", s0, 32'h2345_6789);
    chk("bp_flags_held", {29'd0, co0, of0, z0}, 32'b000);
    chk("bp_in_ready", 32'(ir0), 32'd0);
    chk("bp_out_valid", 32'(ov0), 32'd1);
    iv0 = 0; or0 = 1;
    step();
    chk("bp_release", 32'(ir0), 32'd1);

    // Async reset in the middle of an operation.
    a0 = 32'd1; b0 = 32'd2; sub0 = 0; cin0 = 0; iv0 = 1;
    step();
    iv0 = 0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov0), 32'd0);
    chk("arst_sum", s0, 32'd0);
    chk("arst_in_ready", 32'(ir0), 32'd1);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(ir0), 32'd1);
    op0(32'd3, 32'd4, 1'b0, 1'b0, lat);
    chk("post_rst_sum", s0, 32'd7);
    chk("post_rst_latency", 32'(lat), 32'd8);
    step();

    // Single-digit instance: one cycle per operation.
    a1 = 0; b1 = 0; cin1 = 1; sub1 = 0; iv1 = 1;
    step();
    iv1 = 0;
    lat = 0;
    while (!ov1 && lat < 100) begin
      step();
      lat++;
    end
    chk("d32_latency", 32'(lat), 32'd1);
    chk("d32_sum", s1, 32'd1);
    chk("d32_flags", {29'd0, co1, of1, z1}, 32'b000);

    // 8-bit instance, 2-bit digits: 0x80 - 0x01.
    a2 = 8'h80; b2 = 8'h01; cin2 = 0; sub2 = 1; iv2 = 1;
    step();
    iv2 = 0;
    lat = 0;
    while (!ov2 && lat < 100) begin
      step();
      lat++;
    end
    chk("w8_latency", 32'(lat), 32'd4);
    chk("w8_sum", 32'(s2), 32'h7F);
    chk("w8_flags", {29'd0, co2, of2, z2}, 32'b110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
